// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU/immSrc codes, and the per-state Moore control decode.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
    ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111
  } alu_ctrl_t;

  // Also consumed by the sign-extension unit.
  typedef enum logic [1:0] {
    IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic       active;
    logic       fetch;
    logic       decode;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       reg_write;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.active = (s != S_IDLE);
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.decode    = 1'b1;
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_B:    return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       memReady;
  logic [1:0] immSrc;
  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic       regWrite;
  logic       illegalOp;

  modport master (
    input  op, funct3, funct7b5, zero, memReady,
    output immSrc, pcWrite, adrSrc, memWrite, irWrite, resultSrc,
           aluSrcA, aluSrcB, aluControl, regWrite, illegalOp
  );

  modport slave (
    output op, funct3, funct7b5, zero, memReady,
    input  immSrc, pcWrite, adrSrc, memWrite, irWrite, resultSrc,
           aluSrcA, aluSrcB, aluControl, regWrite, illegalOp
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU control: fixed add/sub, or funct3/funct7 decode for ALU ops.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // op[5] separates R-type from I-type: addi has no subtract form.
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multicycle RV32I datapath; per-state controls are registered
// from the next state, then gated by memReady/zero/op in the current cycle.
//   state      | meaning
//   IDLE       | post-reset bubble, all outputs 0
//   FETCH      | read instr at PC, PC+4 (waits on memReady)
//   DECODE     | compute branch target, dispatch on op
//   MEMADR     | rs1 + imm for lw/sw
//   MEMREAD    | load access (waits on memReady)
//   MEMWB      | write load data to rd
//   MEMWRITE   | store access (waits on memReady)
//   EXECUTER/I | ALU op on rs1,rs2 / rs1,imm
//   ALUWB      | write ALUOut to rd
//   BRANCH     | compare rs1-rs2, conditional PC load
//   JAL        | PC <= target, ALUOut <= oldPC+4
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit RESET_IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  multicycle_ctrl_if.master bus
);

  localparam state_t RST_STATE = RESET_IDLE ? S_IDLE : S_FETCH;

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic       w_pc_update;
  logic [2:0] w_alu_control;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (bus.memReady) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_B:         w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.memReady) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (bus.memReady) w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_ctrl  <= state_ctrl(RST_STATE);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .i_alu_op      (r_ctrl.alu_op),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_op5         (bus.op[5]),
    .o_alu_control (w_alu_control)
  );

  assign w_pc_update    = r_ctrl.pc_update | (r_ctrl.fetch & bus.memReady);
  assign bus.pcWrite    = w_pc_update | (r_ctrl.branch & (bus.zero ^ bus.funct3[0]));
  assign bus.irWrite    = r_ctrl.fetch & bus.memReady;
  assign bus.immSrc     = r_ctrl.active ? imm_src_of(bus.op) : IMM_I;
  assign bus.adrSrc     = r_ctrl.adr_src;
  assign bus.memWrite   = r_ctrl.mem_write;
  assign bus.resultSrc  = r_ctrl.result_src;
  assign bus.aluSrcA    = r_ctrl.alu_src_a;
  assign bus.aluSrcB    = r_ctrl.alu_src_b;
  assign bus.aluControl = w_alu_control;
  assign bus.regWrite   = r_ctrl.reg_write;
  assign bus.illegalOp  = r_ctrl.decode & ~op_legal(bus.op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction phase plans drive a behavioural output
// model compared every cycle, plus literal pins on directed instructions.
module tb_multicycle_ctrl;

  localparam logic [6:0] C_LW  = 7'b0000011;
  localparam logic [6:0] C_SW  = 7'b0100011;
  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_B   = 7'b1100011;
  localparam logic [6:0] C_JAL = 7'b1101111;

  typedef enum int {
    P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
    P_MEMWRITE, P_EXR, P_EXI, P_ALUWB, P_BRANCH, P_JAL
  } ph_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic        exp_valid = 1'b0;
  logic [16:0] exp_vec = '0;
  ph_t         exp_ph = P_IDLE;
  logic [16:0] trace[$];
  logic [16:0] w_out;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_IDLE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign w_out = {bus.immSrc, bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite,
                  bus.resultSrc, bus.aluSrcA, bus.aluSrcB, bus.aluControl,
                  bus.regWrite, bus.illegalOp};

  function automatic logic legal(input logic [6:0] o);
    return (o == C_LW) || (o == C_SW) || (o == C_R) || (o == C_I) ||
           (o == C_B) || (o == C_JAL);
  endfunction

  function automatic logic [2:0] alu_ref(input logic is_r, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b011:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [16:0] model(input ph_t ph, input logic rdy, input logic zr,
                                        input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7);
    logic [1:0] imm, rs, sa, sb;
    logic [2:0] alu;
    logic pcw, adr, mw, irw, rw, ill;
    imm = (o == C_SW) ? 2'b01 : (o == C_B) ? 2'b10 : (o == C_JAL) ? 2'b11 : 2'b00;
    if (ph == P_IDLE) imm = 2'b00;
    {rs, sa, sb, alu, pcw, adr, mw, irw, rw, ill} = '0;
    case (ph)
      P_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; ill = !legal(o); end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  adr = 1'b1;
      P_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      P_EXR:      begin sa = 2'b10; alu = alu_ref(1'b1, f3, f7); end
      P_EXI:      begin sa = 2'b10; sb = 2'b01; alu = alu_ref(1'b0, f3, f7); end
      P_ALUWB:    rw = 1'b1;
      P_BRANCH:   begin sa = 2'b10; alu = 3'b001; pcw = f3[0] ? !zr : zr; end
      P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {imm, pcw, adr, mw, irw, rs, sa, sb, alu, rw, ill};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (w_out !== exp_vec) begin
        errors++;
        $display("FAIL cycle_outputs phase=%s t=%0t got=%b want=%b",
                 exp_ph.name(), $time, w_out, exp_vec);
      end
    end
  end

  task automatic pin(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive(input ph_t ph, input logic rdy, input logic zr);
    bus.memReady = rdy;
    bus.zero     = zr;
    exp_ph       = ph;
    exp_vec      = model(ph, rdy, zr, bus.op, bus.funct3, bus.funct7b5);
    exp_valid    = 1'b1;
    #1 trace.push_back(w_out);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input ph_t ph, input logic rdy, input int zmode);
    logic z;
    z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
    drive(ph, rdy, z);
    tick();
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fwait, input int mwait, input int zmode);
    trace.delete();
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
    repeat (fwait) cyc(P_FETCH, 1'b0, 2);
    cyc(P_FETCH, 1'b1, 2);
    cyc(P_DECODE, 1'($urandom), 2);
    case (o)
      C_LW: begin
        cyc(P_MEMADR, 1'($urandom), 2);
        repeat (mwait) cyc(P_MEMREAD, 1'b0, 2);
        cyc(P_MEMREAD, 1'b1, 2);
        cyc(P_MEMWB, 1'($urandom), 2);
      end
      C_SW: begin
        cyc(P_MEMADR, 1'($urandom), 2);
        repeat (mwait) cyc(P_MEMWRITE, 1'b0, 2);
        cyc(P_MEMWRITE, 1'b1, 2);
      end
      C_R:   begin cyc(P_EXR, 1'($urandom), 2); cyc(P_ALUWB, 1'($urandom), 2); end
      C_I:   begin cyc(P_EXI, 1'($urandom), 2); cyc(P_ALUWB, 1'($urandom), 2); end
      C_B:   cyc(P_BRANCH, 1'($urandom), zmode);
      C_JAL: begin cyc(P_JAL, 1'($urandom), 2); cyc(P_ALUWB, 1'($urandom), 2); end
      default: ;
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [16:0] v;
    logic [6:0]  o;
    int          n;
    bus.op = C_LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.memReady = 1'b0;
    @(posedge clk); #1;
    cyc(P_IDLE, 1'b1, 2);
    rst = 1'b0;
    cyc(P_IDLE, 1'b1, 2);

    // Abandon an lw stalled in MEMREAD.
    bus.op = C_LW;
    cyc(P_FETCH, 1'b1, 2);
    cyc(P_DECODE, 1'b1, 2);
    cyc(P_MEMADR, 1'b1, 2);
    cyc(P_MEMREAD, 1'b0, 2);
    rst = 1'b1;
    drive(P_IDLE, 1'b1, 1'b1);
    pin("reset_outputs_zero", trace[$], 17'h0);
    tick();
    rst = 1'b0;
    cyc(P_IDLE, 1'b1, 2);

    run_instr(C_LW, 3'b010, 1'b0, 0, 0, 2);
    v = trace[0]; pin("post_reset_fetch_irwrite", 17'(v[11]), 17'd1);
    pin("lw_cycles", 17'(trace.size()), 17'd5);
    v = trace[3]; pin("lw_memread_regwrite", 17'(v[1]), 17'd0);
    v = trace[4]; pin("lw_memwb_regwrite", 17'(v[1]), 17'd1);
    pin("lw_memwb_resultsrc", 17'(v[10:9]), 17'b01);
    pin("lw_immsrc", 17'(v[16:15]), 17'b00);

    run_instr(C_SW, 3'b010, 1'b0, 0, 3, 2);
    n = 0;
    foreach (trace[i]) begin v = trace[i]; if (v[12]) n++; end
    pin("sw_memwrite_cycles", 17'(n), 17'd4);
    pin("sw_cycles", 17'(trace.size()), 17'd7);
    v = trace[3]; pin("sw_immsrc", 17'(v[16:15]), 17'b01);

    run_instr(C_B, 3'b000, 1'b0, 0, 0, 1);
    v = trace[2];
    pin("beq_taken_pcwrite", 17'(v[14]), 17'd1);
    pin("beq_alucontrol", 17'(v[4:2]), 17'b001);
    pin("beq_immsrc", 17'(v[16:15]), 17'b10);
    run_instr(C_B, 3'b001, 1'b0, 0, 0, 1);
    v = trace[2];
    pin("bne_not_taken_pcwrite", 17'(v[14]), 17'd0);
    pin("bne_alucontrol", 17'(v[4:2]), 17'b001);

    run_instr(C_R, 3'b000, 1'b1, 0, 0, 2);
    v = trace[2]; pin("r_sub_alucontrol", 17'(v[4:2]), 17'b001);
    run_instr(C_I, 3'b000, 1'b1, 0, 0, 2);
    v = trace[2]; pin("i_add_alucontrol", 17'(v[4:2]), 17'b000);
    run_instr(C_R, 3'b110, 1'b0, 0, 0, 2);
    v = trace[2]; pin("r_or_alucontrol", 17'(v[4:2]), 17'b011);
    run_instr(C_I, 3'b110, 1'b1, 0, 0, 2);
    v = trace[2]; pin("i_or_alucontrol", 17'(v[4:2]), 17'b011);

    run_instr(C_JAL, 3'b000, 1'b0, 0, 0, 2);
    v = trace[2];
    pin("jal_immsrc", 17'(v[16:15]), 17'b11);
    pin("jal_pcwrite", 17'(v[14]), 17'd1);
    pin("jal_alusrca", 17'(v[8:7]), 17'b01);
    pin("jal_alusrcb", 17'(v[6:5]), 17'b10);
    v = trace[3]; pin("jal_aluwb_regwrite", 17'(v[1]), 17'd1);

    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 2);
    v = trace[1]; pin("illegal_pulse", 17'(v[0]), 17'd1);
    pin("illegal_cycles", 17'(trace.size()), 17'd2);

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 6))
        0: o = C_LW;
        1: o = C_SW;
        2: o = C_R;
        3: o = C_I;
        4: o = C_B;
        5: o = C_JAL;
        default: begin
          o = 7'($urandom);
          while (legal(o)) o = 7'($urandom);
        end
      endcase
      run_instr(o, 3'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 2);
    end

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
